// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction-fetch stage
// Purpose: IF/ID payload type, buffered fetch entry type and the canonical NOP.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcplus4;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response bus
// Purpose: groups the imem request channel (valid/ready/addr) and the
// in-order response channel (valid/data).
// master: fetch stage side; slave: instruction memory side.
interface fetch_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// rtl/fetch_unit_fifo.sv - small synchronous FIFO with clear, count, full/empty
// Purpose: buffers fetched entries; also used as the in-flight PC queue.
// Ports: clk, rst (async, active-high), clear (sync flush), push/push_data,
//        pop/head (first-word fall-through), count, full, empty.
module fetch_unit_fifo
  import fetch_unit_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  T                 push_data,
  input  logic             pop,
  output T                 head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage feeding the IF/ID register
// Purpose: owns the PC, issues credit-limited word fetches, buffers in-order
// responses and loads IF/ID, honouring redirect, flush and stall.
// Ports: clk, reset (async, active-high); imem (master side of the imem bus);
//        stall_d/flush_d from hazard unit; pcsrc_e/pctarget_e redirect from EX;
//        valid_d/instr_d/if_id_d form the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  fetch_unit_if.master        imem,
  input  logic                stall_d,
  input  logic                flush_d,
  input  logic                pcsrc_e,
  input  logic [31:0]         pctarget_e,
  output logic                valid_d,
  output logic [31:0]         instr_d,
  output if_id_t              if_id_d
);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int DROP_W = 8;

  logic [31:0]       pc_q, pc_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [31:0]       ifid_instr_q, ifid_instr_d;
  if_id_t            ifid_q, ifid_d;

  logic [31:0]       pcq_head;
  logic [CNT_W-1:0]  pcq_count, dq_count;
  logic              pcq_full, pcq_empty, dq_full, dq_empty;
  fetch_entry_t      dq_head;

  logic credit_ok, req_fire, rsp_drop, rsp_take, load_ok, bypass, dq_push, dq_pop;

  // The PC queue occupancy is the number of requests still awaiting a response.
  assign credit_ok      = (int'(pcq_count) + int'(dq_count)) < DEPTH;
  assign imem.req_valid = !reset && !pcsrc_e && credit_ok && !pcq_full && !dq_full;
  assign imem.req_addr  = pc_q;
  assign req_fire       = imem.req_valid && imem.req_ready;

  // Responses belonging to requests issued before a redirect are discarded first.
  assign rsp_drop = imem.rsp_valid && (drop_q != '0);
  assign rsp_take = imem.rsp_valid && (drop_q == '0) && !pcq_empty;

  assign load_ok  = !pcsrc_e && !flush_d && !stall_d;
  assign bypass   = load_ok && dq_empty && rsp_take;
  assign dq_pop   = load_ok && !dq_empty;
  assign dq_push  = rsp_take && !pcsrc_e && !bypass;

  fetch_unit_fifo #(.DEPTH(DEPTH), .T(logic [31:0])) u_pc_queue (
    .clk       (clk),
    .rst       (reset),
    .clear     (pcsrc_e),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (rsp_take),
    .head      (pcq_head),
    .count     (pcq_count),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

  fetch_unit_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_data_fifo (
    .clk       (clk),
    .rst       (reset),
    .clear     (pcsrc_e),
    .push      (dq_push),
    .push_data ('{pc: pcq_head, instr: imem.rsp_data}),
    .pop       (dq_pop),
    .head      (dq_head),
    .count     (dq_count),
    .full      (dq_full),
    .empty     (dq_empty)
  );

  always_comb begin
    pc_d         = pc_q;
    drop_d       = drop_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_d       = ifid_q;
    if (pcsrc_e) begin
      pc_d         = pctarget_e;
      // Everything still in flight becomes stale, including any response this cycle.
      drop_d       = drop_q + DROP_W'(pcq_count) - DROP_W'(rsp_drop || rsp_take);
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      ifid_d       = '0;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp_drop) begin
        drop_d = drop_q - 1'b1;
      end
      if (flush_d) begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
        ifid_d       = '0;
      end else if (!stall_d) begin
        if (!dq_empty) begin
          ifid_valid_d = 1'b1;
          ifid_instr_d = dq_head.instr;
          ifid_d       = '{pc: dq_head.pc, pcplus4: dq_head.pc + 32'd4};
        end else if (rsp_take) begin
          ifid_valid_d = 1'b1;
          ifid_instr_d = imem.rsp_data;
          ifid_d       = '{pc: pcq_head, pcplus4: pcq_head + 32'd4};
        end else begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
          ifid_d       = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      drop_q       <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_q       <= '0;
    end else begin
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_q       <= ifid_d;
    end
  end

  assign valid_d = ifid_valid_q;
  assign instr_d = ifid_instr_q;
  assign if_id_d = ifid_q;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage RISC-V pipeline, directly upstream of decode. Owns the PC, issues word requests to instruction memory over a valid/ready request channel, and buffers in-order responses in a small FIFO. Drives the IF/ID pipeline register (`if_id_t` plus instruction word) into decode. Honours hazard-unit stall/flush and EX-stage branch/jump redirects.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `DEPTH`, 2, FIFO entries; also the maximum number of requests in flight plus buffered (credit limit). Must be ≥1.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `imem_req_valid` out 1: fetch request.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: fetch address (= PC).
- `imem_rsp_valid` in 1: response word valid, in request order, latency ≥1 cycle.
- `imem_rsp_data` in 32: instruction word.
- `stall_d` in 1: hold the IF/ID register; no pop.
- `flush_d` in 1: load a bubble into IF/ID.
- `pcsrc_e` in 1: redirect taken in EX.
- `pctarget_e` in 32: redirect target.
- `valid_d` out 1: IF/ID holds a real instruction.
- `instr_d` out 32: instruction word.
- `if_id_d` out `if_id_t`: {pc, pcplus4} of `instr_d`.

## Operation
- Request: `imem_req_valid` = !reset && !pcsrc_e && (outstanding + fifo_count < DEPTH). On handshake: PC <= PC+4 (mod 2^32), outstanding++. `imem_req_addr` stable while valid && !ready.
- Response: if drop_cnt>0, discard and drop_cnt--. Otherwise pair the word with the PC of its request and enqueue; outstanding--. A request-side PC queue of DEPTH tracks the in-flight PCs.
- Bypass: if the FIFO is empty, a response arrives, and IF/ID may load, the response loads IF/ID directly.
- IF/ID load when !stall_d: head entry (or bypass) -> valid_d=1, pop. If nothing is available: valid_d=0, instr_d=NOP.
- Priority per edge: reset > pcsrc_e > flush_d > stall_d > normal.
- `pcsrc_e` effects:
  - PC <= pctarget_e.
  - FIFO and PC queue cleared.
  - drop_cnt <= outstanding − (non-dropped response this cycle ? 1 : 0) + drop_cnt − (dropped response this cycle ? 1 : 0).
  - outstanding <= 0.
  - IF/ID <= bubble.
  - No request that cycle.
- `flush_d` without redirect: IF/ID <= bubble (valid_d=0, instr_d=NOP, if_id_d=0). The FIFO is not popped, and fetch continues.
- `stall_d` with no flush: IF/ID holds. FIFO fills; credits stop requests once full.
- PC alignment is not checked; the target is issued as given.

## Timing
- Reset values:
  - PC=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty.
  - `valid_d`=0, `instr_d`=32'h0000_0013, `if_id_d`=0.
  - `imem_req_valid`=0 while reset is asserted, 1 in the first cycle after release.
- Latency: request accepted cycle N, response cycle N+L. `valid_d`=1 from cycle N+L+1 if the FIFO is empty and there is no stall.
- Steady state with L=1 and DEPTH=2: one instruction per cycle.
- Redirect penalty: target request in cycle R+1. First target instruction at `valid_d` in R+2+L.
- A stale response in the same cycle as `pcsrc_e` is discarded.
- Reset mid-transaction: in-flight memory responses after release are not tracked. The memory side must also be reset.

## Structure
- `types` package: add `fetch_entry_t` {logic [31:0] pc; logic [31:0] instr;}. Reuse `if_id_t`.
- `constants` package: add `NOP_INSTR = 32'h0000_0013`.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t` with clear, count, and full/empty flags; also instantiated as the in-flight PC queue.

## Test plan
- Reset release, ready=1, L=1 -> addresses 0,4,8,… each cycle. `valid_d` first high in cycle 2 with pc=0, pcplus4=4, instr = the returned word.
- `stall_d` held 4 cycles -> IF/ID unchanged. `imem_req_valid` drops after DEPTH credits are used. Release -> buffered words pc=4,8 delivered in order, with no loss or duplicate.
- `pcsrc_e` with target 0x100 while 2 requests are outstanding (L=3) -> both late responses discarded, `valid_d`=0 during the gap, next `valid_d` shows pc=0x100.
- `flush_d` for one cycle -> `instr_d`=0x00000013 and `valid_d`=0 for that cycle. The following instruction is not skipped.
- `imem_req_ready` low for 3 cycles -> `imem_req_addr` and `imem_req_valid` stable. PC advances only on the handshake.
- Reset asserted mid-stream -> all outputs return to reset values asynchronously, and the next request goes to RESET_PC.
